// File: rtl/pipeline_scoreboard_if.sv
// Decode/issue, writeback-retire and status signals of the register scoreboard.
// master drives issue and retire traffic; slave is the scoreboard itself.
interface pipeline_scoreboard_if #(
    parameter int unsigned NREGS = 32,
    parameter int unsigned NRF   = 2,
    parameter int unsigned LATW  = 5
);
    localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned FW = (NRF > 1) ? $clog2(NRF) : 1;
    localparam int unsigned CW = $clog2(NRF * NREGS + 1);

    logic                   issue_valid;
    logic                   issue_we;
    logic [RW-1:0]          issue_rd;
    logic [FW-1:0]          issue_rd_rf;
    logic [LATW-1:0]        issue_lat;
    logic [2:0]             issue_rs_use;
    logic [RW-1:0]          issue_rs1;
    logic [FW-1:0]          issue_rs1_rf;
    logic [RW-1:0]          issue_rs2;
    logic [FW-1:0]          issue_rs2_rf;
    logic [RW-1:0]          issue_rs3;
    logic [FW-1:0]          issue_rs3_rf;
    logic                   flush;
    logic                   wb_valid;
    logic [RW-1:0]          wb_rd;
    logic [FW-1:0]          wb_rf;
    logic                   stall;
    logic                   issue_accept;
    logic [NRF*NREGS-1:0]   busy_vec;
    logic [CW-1:0]          pending_cnt;

    modport master (
        output issue_valid, issue_we, issue_rd, issue_rd_rf, issue_lat, issue_rs_use,
        output issue_rs1, issue_rs1_rf, issue_rs2, issue_rs2_rf, issue_rs3, issue_rs3_rf,
        output flush, wb_valid, wb_rd, wb_rf,
        input  stall, issue_accept, busy_vec, pending_cnt
    );

    modport slave (
        input  issue_valid, issue_we, issue_rd, issue_rd_rf, issue_lat, issue_rs_use,
        input  issue_rs1, issue_rs1_rf, issue_rs2, issue_rs2_rf, issue_rs3, issue_rs3_rf,
        input  flush, wb_valid, wb_rd, wb_rf,
        output stall, issue_accept, busy_vec, pending_cnt
    );
endinterface

// File: rtl/pipeline_scoreboard.sv
// Per-register pending-write scoreboard: fixed-latency countdowns plus variable-latency
// entries retired by writeback; raises the decode stall on RAW/WAW hazards.
module pipeline_scoreboard #(
    parameter int unsigned NREGS    = 32,
    parameter int unsigned NRF      = 2,
    parameter int unsigned LATW     = 5,
    parameter bit          ZERO_RF0 = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_scoreboard_if.slave sb
);
    localparam int unsigned RW = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int unsigned FW = (NRF > 1) ? $clog2(NRF) : 1;
    localparam int unsigned NE = NRF * NREGS;
    localparam int unsigned EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int unsigned CW = $clog2(NE + 1);

    logic [NE-1:0]   busy_q, busy_d;
    logic [LATW-1:0] cnt_q [NE];
    logic [LATW-1:0] cnt_d [NE];
    logic [CW-1:0]   pend_q, pend_d;

    logic [RW-1:0]   rs_reg [3];
    logic [FW-1:0]   rs_rf  [3];
    logic [EW-1:0]   src_e;
    logic [EW-1:0]   rd_e;
    logic [EW-1:0]   wb_e;
    logic            rd_ok;
    logic            wb_ok;
    logic            rd_zero;
    logic            raw;
    logic            waw;
    logic            stall;
    logic            accept;
    logic            set_ok;

    function automatic logic in_range(input logic [FW-1:0] f, input logic [RW-1:0] r);
        return (32'(f) < NRF) && (32'(r) < NREGS);
    endfunction

    function automatic logic [EW-1:0] ent(input logic [FW-1:0] f, input logic [RW-1:0] r);
        return EW'(32'(f) * NREGS + 32'(r));
    endfunction

    always_comb begin
        rs_reg[0] = sb.issue_rs1;
        rs_reg[1] = sb.issue_rs2;
        rs_reg[2] = sb.issue_rs3;
        rs_rf[0]  = sb.issue_rs1_rf;
        rs_rf[1]  = sb.issue_rs2_rf;
        rs_rf[2]  = sb.issue_rs3_rf;
    end

    always_comb begin
        rd_ok   = in_range(sb.issue_rd_rf, sb.issue_rd);
        rd_e    = ent(sb.issue_rd_rf, sb.issue_rd);
        wb_ok   = sb.wb_valid && in_range(sb.wb_rf, sb.wb_rd);
        wb_e    = ent(sb.wb_rf, sb.wb_rd);
        rd_zero = ZERO_RF0 && (sb.issue_rd_rf == '0) && (sb.issue_rd == '0);
    end

    // A busy source is still usable on its final countdown stage or when it retires now.
    always_comb begin
        raw   = 1'b0;
        src_e = '0;
        for (int s = 0; s < 3; s++) begin
            if (sb.issue_rs_use[s] && in_range(rs_rf[s], rs_reg[s])) begin
                src_e = ent(rs_rf[s], rs_reg[s]);
                if (busy_q[src_e] && (cnt_q[src_e] != LATW'(1)) &&
                    !(wb_ok && (wb_e == src_e))) begin
                    raw = 1'b1;
                end
            end
        end
    end

    always_comb begin
        waw = sb.issue_we && rd_ok && busy_q[rd_e] && (cnt_q[rd_e] != LATW'(1)) &&
              !(wb_ok && (wb_e == rd_e));
        stall  = sb.issue_valid && (raw || waw) && !rst;
        accept = sb.issue_valid && !stall && !sb.flush && !rst;
        set_ok = accept && sb.issue_we && rd_ok && !rd_zero;
    end

    // Priority on one entry: countdown, then retire, then a new accept overrides both.
    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        pend_d = '0;
        for (int e = 0; e < NE; e++) begin
            if (busy_q[e] && (cnt_q[e] != '0)) begin
                cnt_d[e] = cnt_q[e] - LATW'(1);
                if (cnt_q[e] == LATW'(1)) begin
                    busy_d[e] = 1'b0;
                end
            end
        end
        if (wb_ok) begin
            busy_d[wb_e] = 1'b0;
            cnt_d[wb_e]  = '0;
        end
        if (set_ok) begin
            busy_d[rd_e] = 1'b1;
            cnt_d[rd_e]  = sb.issue_lat;
        end
        for (int e = 0; e < NE; e++) begin
            pend_d = pend_d + CW'(busy_d[e]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
            pend_q <= '0;
            for (int e = 0; e < NE; e++) begin
                cnt_q[e] <= '0;
            end
        end else begin
            busy_q <= busy_d;
            pend_q <= pend_d;
            for (int e = 0; e < NE; e++) begin
                cnt_q[e] <= cnt_d[e];
            end
        end
    end

    assign sb.stall        = stall;
    assign sb.issue_accept = accept;
    assign sb.busy_vec     = busy_q;
    assign sb.pending_cnt  = pend_q;
endmodule

// File: tb/tb_pipeline_scoreboard.sv
// Directed bench for pipeline_scoreboard: the driver queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_scoreboard;
    typedef struct {
        bit          stall;
        bit          acc;
        logic [63:0] busy;
        int          pend;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;

    pipeline_scoreboard_if sb ();

    pipeline_scoreboard dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] b(input int n);
        logic [63:0] one;
        one = 64'd1;
        return one << n;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("stall", 64'(sb.stall), 64'(e.stall));
            check("issue_accept", 64'(sb.issue_accept), 64'(e.acc));
            check("busy_vec", 64'(sb.busy_vec), e.busy);
            check("pending_cnt", 64'(sb.pending_cnt), 64'(e.pend));
        end
    end

    task automatic clr();
        sb.issue_valid  = 1'b0;
        sb.issue_we     = 1'b0;
        sb.issue_rd     = '0;
        sb.issue_rd_rf  = '0;
        sb.issue_lat    = '0;
        sb.issue_rs_use = '0;
        sb.issue_rs1    = '0;
        sb.issue_rs1_rf = '0;
        sb.issue_rs2    = '0;
        sb.issue_rs2_rf = '0;
        sb.issue_rs3    = '0;
        sb.issue_rs3_rf = '0;
        sb.flush        = 1'b0;
        sb.wb_valid     = 1'b0;
        sb.wb_rd        = '0;
        sb.wb_rf        = '0;
    endtask

    task automatic set_issue(input int rd, input int rf, input int lat);
        sb.issue_valid = 1'b1;
        sb.issue_we    = 1'b1;
        sb.issue_rd    = rd[4:0];
        sb.issue_rd_rf = rf[0:0];
        sb.issue_lat   = lat[4:0];
    endtask

    task automatic set_src(input int s, input int r, input int f);
        sb.issue_valid     = 1'b1;
        sb.issue_rs_use[s] = 1'b1;
        case (s)
            0: begin sb.issue_rs1 = r[4:0]; sb.issue_rs1_rf = f[0:0]; end
            1: begin sb.issue_rs2 = r[4:0]; sb.issue_rs2_rf = f[0:0]; end
            default: begin sb.issue_rs3 = r[4:0]; sb.issue_rs3_rf = f[0:0]; end
        endcase
    endtask

    task automatic set_wb(input int r, input int f);
        sb.wb_valid = 1'b1;
        sb.wb_rd    = r[4:0];
        sb.wb_rf    = f[0:0];
    endtask

    // Queue this cycle's expectation, then advance to the next drive point.
    task automatic tick(input bit es, input bit ea, input logic [63:0] eb, input int ep);
        exp_t e;
        e.stall = es;
        e.acc   = ea;
        e.busy  = eb;
        e.pend  = ep;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        rst = 1'b1;
        clr();
        @(posedge clk);
        #1;
        // reset held: issue must not be accepted
        set_issue(1, 0, 3);            tick(0, 0, 64'd0, 0);
        rst = 1'b0;
        // x0 in rf 0 is never marked busy
        set_issue(0, 0, 3);            tick(0, 1, 64'd0, 0);
        tick(0, 0, 64'd0, 0);
        // fixed latency 3 on x5
        set_issue(5, 0, 3);            tick(0, 1, 64'd0, 0);
        set_src(0, 5, 0);              tick(1, 0, b(5), 1);
        set_src(0, 5, 0);              tick(1, 0, b(5), 1);
        set_src(0, 5, 0);              tick(0, 1, b(5), 1);
        tick(0, 0, 64'd0, 0);
        // variable latency on x7, released by writeback bypass
        set_issue(7, 0, 0);            tick(0, 1, 64'd0, 0);
        set_src(1, 7, 0);              tick(1, 0, b(7), 1);
        set_src(1, 7, 0);              tick(1, 0, b(7), 1);
        set_src(1, 7, 0); set_wb(7, 0); tick(0, 1, b(7), 1);
        tick(0, 0, 64'd0, 0);
        // FPR isolation: f3 busy, x3 free
        set_issue(3, 1, 4);            tick(0, 1, 64'd0, 0);
        set_src(0, 3, 0);              tick(0, 1, b(35), 1);
        set_src(2, 3, 1);              tick(1, 0, b(35), 1);
        set_src(2, 3, 1);              tick(1, 0, b(35), 1);
        set_src(2, 3, 1);              tick(0, 1, b(35), 1);
        tick(0, 0, 64'd0, 0);
        // same-cycle retire and new accept on x9, then flush
        set_issue(9, 0, 0);            tick(0, 1, 64'd0, 0);
        set_issue(9, 0, 2); set_wb(9, 0); tick(0, 1, b(9), 1);
        set_src(0, 9, 0);              tick(1, 0, b(9), 1);
        set_issue(10, 0, 3); set_src(0, 9, 0); sb.flush = 1'b1; tick(0, 0, b(9), 1);
        tick(0, 0, 64'd0, 0);
        // WAW on x4, reset mid-wait
        set_issue(4, 0, 0);            tick(0, 1, 64'd0, 0);
        set_issue(4, 0, 2);            tick(1, 0, b(4), 1);
        set_issue(4, 0, 2);            tick(1, 0, b(4), 1);
        rst = 1'b1; set_issue(4, 0, 2); tick(0, 0, b(4), 1);
        rst = 1'b0; set_issue(4, 0, 2); tick(0, 1, 64'd0, 0);
        tick(0, 0, b(4), 1);
        tick(0, 0, b(4), 1);
        // retire to a non-busy entry is ignored
        set_wb(12, 0);                 tick(0, 0, 64'd0, 0);
        tick(0, 0, 64'd0, 0);
        // latency 1: back-to-back dependent issue and rewrite never stall
        set_issue(6, 0, 1);            tick(0, 1, 64'd0, 0);
        set_issue(6, 0, 1); set_src(0, 6, 0); set_src(1, 6, 0); tick(0, 1, b(6), 1);
        tick(0, 0, b(6), 1);
        tick(0, 0, 64'd0, 0);
        // two variable-latency entries across both files
        set_issue(1, 0, 0);            tick(0, 1, 64'd0, 0);
        set_issue(2, 1, 0);            tick(0, 1, b(1), 1);
        tick(0, 0, b(1) | b(34), 2);
        set_wb(1, 0);                  tick(0, 0, b(1) | b(34), 2);
        set_wb(2, 1);                  tick(0, 0, b(34), 1);
        tick(0, 0, 64'd0, 0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
